// File: rtl/dac_adc_pkg.sv
// Shared DAC/ADC test-path types: sample width and word type used by the
// test controller, the SPI transfer block and the DAC/ADC data paths.
package dac_adc_pkg;

  localparam int SPI_WIDTH    = 16;
  localparam int SPI_CLK_DIV  = 4;
  localparam int SPI_CS_SETUP = 2;

  typedef logic [SPI_WIDTH-1:0] sample_t;

endpackage

// File: rtl/dac_adc_spi_xfer_clk_gen.sv
// SPI mode-0 clock generator: sclk toggles every CLK_DIV cycles while enabled,
// with one-cycle strobes marking the clock edge at which sclk rises or falls.
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic sclk,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic          sclk_q, sclk_d;
  logic          edge_now;

  always_comb begin
    edge_now = enable && (div_q == DIV_LAST);
    div_d    = div_q;
    sclk_d   = sclk_q;
    if (!enable) begin
      div_d  = '0;
      sclk_d = 1'b0;
    end else if (edge_now) begin
      div_d  = '0;
      sclk_d = ~sclk_q;
    end else begin
      div_d  = div_q + DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      sclk_q <= sclk_d;
    end
  end

  // Strobes name the edge sclk_q takes at the upcoming clk edge.
  assign rise_stb = edge_now && !sclk_q;
  assign fall_stb = edge_now &&  sclk_q;
  assign sclk     = sclk_q;

endmodule

// File: rtl/dac_adc_spi_xfer.sv
// Full-duplex SPI master for the DAC/ADC test path: one begin pulse shifts
// tx_word out on spi_mosi (MSB first) while capturing spi_miso into rx_word.
module dac_adc_spi_xfer
  import dac_adc_pkg::*;
#(
  parameter int WIDTH    = SPI_WIDTH,
  parameter int CLK_DIV  = SPI_CLK_DIV,
  parameter int CS_SETUP = SPI_CS_SETUP
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             begin_transmit,
  input  logic [WIDTH-1:0] tx_word,
  output logic [WIDTH-1:0] rx_word,
  output logic             busy,
  output logic             done,
  output logic             spi_sclk,
  output logic             spi_cs_n,
  output logic             spi_mosi,
  input  logic             spi_miso,
  output logic [2:0]       dbg_state
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int SW = $clog2(CS_SETUP + 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(WIDTH - 1);
  localparam logic [SW-1:0] SETUP_LAST = SW'(CS_SETUP - 1);

  typedef enum logic [2:0] {
    s_idle  = 3'd0,
    s_setup = 3'd1,
    s_shift = 3'd2,
    s_hold  = 3'd3,
    s_done  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    setup_cnt_q, setup_cnt_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [WIDTH-1:0] rx_word_q, rx_word_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cs_n_q, cs_n_d;
  logic             mosi_q, mosi_d;

  logic clk_en;
  logic sclk;
  logic rise_stb;
  logic fall_stb;

  assign clk_en = (state_q == s_shift);

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk      (CLOCK_50),
    .rst      (reset),
    .enable   (clk_en),
    .sclk     (sclk),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  // Handshake: begin_transmit is sampled only in s_idle (busy=0); a pulse while
  // busy is dropped, never queued. done is a one-cycle pulse with rx_word valid.
  always_comb begin
    state_d     = state_q;
    setup_cnt_d = setup_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    tx_sh_d     = tx_sh_q;
    rx_sh_d     = rx_sh_q;
    rx_word_d   = rx_word_q;
    done_d      = 1'b0;
    cs_n_d      = cs_n_q;
    mosi_d      = mosi_q;

    case (state_q)
      s_idle: begin
        cs_n_d = 1'b1;
        mosi_d = 1'b0;
        if (begin_transmit) begin
          state_d = s_setup;
          tx_sh_d = tx_word;
          cs_n_d  = 1'b0;
        end
      end
      s_setup: begin
        if (setup_cnt_q == SETUP_LAST) begin
          state_d = s_shift;
          mosi_d  = tx_sh_q[WIDTH-1];
        end else begin
          setup_cnt_d = setup_cnt_q + SW'(1);
        end
      end
      s_shift: begin
        if (rise_stb) begin
          rx_sh_d = {rx_sh_q[WIDTH-2:0], spi_miso};
        end
        if (fall_stb) begin
          tx_sh_d = tx_sh_q << 1;
          mosi_d  = tx_sh_q[WIDTH-2];
          if (bit_cnt_q == BIT_LAST) begin
            state_d = s_hold;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      s_hold: begin
        if (setup_cnt_q == SETUP_LAST) begin
          state_d   = s_done;
          cs_n_d    = 1'b1;
          done_d    = 1'b1;
          rx_word_d = rx_sh_q;
          mosi_d    = 1'b0;
        end else begin
          setup_cnt_d = setup_cnt_q + SW'(1);
        end
      end
      s_done: begin
        state_d = s_idle;
      end
      default: begin
        state_d = s_idle;
        cs_n_d  = 1'b1;
        mosi_d  = 1'b0;
      end
    endcase

    // Every state starts its counters from zero.
    if (state_d != state_q) begin
      setup_cnt_d = '0;
      bit_cnt_d   = '0;
    end

    busy_d = (state_d != s_idle);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= s_idle;
      setup_cnt_q <= '0;
      bit_cnt_q   <= '0;
      tx_sh_q     <= '0;
      rx_sh_q     <= '0;
      rx_word_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      setup_cnt_q <= setup_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_sh_q     <= tx_sh_d;
      rx_sh_q     <= rx_sh_d;
      rx_word_q   <= rx_word_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cs_n_q      <= cs_n_d;
      mosi_q      <= mosi_d;
    end
  end

  assign rx_word   = rx_word_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign spi_sclk  = sclk;
  assign spi_cs_n  = cs_n_q;
  assign spi_mosi  = mosi_q;
  assign dbg_state = state_q;

endmodule
